// File: rtl/mm_pkg.sv
// Shared types and helpers for the 3x3 matrix-multiply MAC sequencer.
// Element [r][c] of a flat operand sits at bit offset (3r+c)*WIDTH.
package mm_pkg;

    localparam int WIDTH_DEF = 4;

    // Wide enough for three full-scale products summed together.
    function automatic int acc_w(input int w);
        return 2 * w + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT,
        DONE
    } state_t;

    typedef logic [1:0] idx_t;

    function automatic int elem_lsb(input idx_t r, input idx_t c, input int w);
        return (3 * int'(r) + int'(c)) * w;
    endfunction

endpackage

// File: rtl/mm_mac_pe.sv
// Single multiply-accumulate processing element: combinational product,
// registered accumulator with synchronous clear taking priority over enable.
module mm_mac_pe
    import mm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_W = acc_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    input  logic             en,
    output logic [ACC_W-1:0] acc
);

    logic [2*WIDTH-1:0] prod;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;

    assign prod = a * b;

    // NOTE: next-state defaults to the held value first, so no path can infer a latch.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W - 2 * WIDTH){1'b0}}, prod};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mm3x3_mac_sched.sv
// Computes C = A x B for 3x3 unsigned matrices on one shared MAC, walking C in
// row-major order and streaming each element out on a valid/ready port.
module mm3x3_mac_sched
    import mm_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int ACC_W = acc_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [9*WIDTH-1:0] a_flat,
    input  logic [9*WIDTH-1:0] b_flat,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ACC_W-1:0]   res_data,
    output logic [1:0]         res_row,
    output logic [1:0]         res_col,
    output logic               done
);

    state_t             state_q;
    idx_t               i_q, j_q, k_q;
    logic [9*WIDTH-1:0] a_q, b_q;
    logic               busy_q, valid_q, done_q;

    logic [9*WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH-1:0]   pe_a, pe_b;
    logic               pe_clr, pe_en;
    logic [ACC_W-1:0]   pe_acc;

    // Shifting instead of a variable part-select keeps the index width honest.
    assign a_sel = a_q >> elem_lsb(i_q, k_q, WIDTH);
    assign b_sel = b_q >> elem_lsb(k_q, j_q, WIDTH);
    assign pe_a  = a_sel[WIDTH-1:0];
    assign pe_b  = b_sel[WIDTH-1:0];

    assign pe_en  = (state_q == CALC);
    assign pe_clr = ((state_q == IDLE) && start) || ((state_q == OUT) && res_ready);

    mm_mac_pe #(
        .WIDTH(WIDTH),
        .ACC_W(ACC_W)
    ) u_pe (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (pe_a),
        .b    (pe_b),
        .clr  (pe_clr),
        .en   (pe_en),
        .acc  (pe_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            // NOTE: operand registers are reset too; they are small and the outputs must read zero.
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a_flat;
                        b_q     <= b_flat;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (k_q == 2'd2) begin
                        k_q     <= '0;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        valid_q <= 1'b0;
                        if ((i_q == 2'd2) && (j_q == 2'd2)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            if (j_q == 2'd2) begin
                                j_q <= '0;
                                i_q <= i_q + 2'd1;
                            end else begin
                                j_q <= j_q + 2'd1;
                            end
                            state_q <= CALC;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = valid_q;
    assign res_data  = valid_q ? pe_acc : '0;
    assign res_row   = valid_q ? i_q : '0;
    assign res_col   = valid_q ? j_q : '0;

endmodule

// File: tb/tb_mm3x3_mac_sched.sv
// Directed bench for mm3x3_mac_sched: hand-computed products, edge-exact
// acceptance timing, backpressure, ignored start and mid-run reset.
module tb_mm3x3_mac_sched;

    localparam int W = 4;
    localparam int AW = 2 * W + 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [9*W-1:0] a_flat;
    logic [9*W-1:0] b_flat;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_data;
    logic [1:0]    res_row;
    logic [1:0]    res_col;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;

    int m_seq[9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int m_id[9]   = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int m_b2[9]   = '{15, 0, 7, 1, 2, 3, 9, 8, 4};
    int m_max[9]  = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
    int c_seq[9]  = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    int c_max[9]  = '{675, 675, 675, 675, 675, 675, 675, 675, 675};

    mm3x3_mac_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_flat   (a_flat),
        .b_flat   (b_flat),
        .busy     (busy),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_row  (res_row),
        .res_col  (res_col),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9*W-1:0] pack(input int m[9]);
        logic [9*W-1:0] p;
        p = '0;
        for (int e = 0; e < 9; e++) p[e*W +: W] = 4'(m[e]);
        return p;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_valid"}, 32'(res_valid), 0);
        check({tag, "_data"},  32'(res_data), 0);
        check({tag, "_row"},   32'(res_row), 0);
        check({tag, "_col"},   32'(res_col), 0);
        check({tag, "_done"},  32'(done), 0);
    endtask

    // One full multiplication; stall_n/abort_n select an element to stall or abort on (-1 = none).
    task automatic run_mm(input string name, input logic [9*W-1:0] a, input logic [9*W-1:0] b,
                          input int exp_c[9], input int stall_n, input bit poke_start,
                          input int abort_n);
        int t0, off, d0, w;
        @(negedge clk);
        a_flat = a;
        b_flat = b;
        start = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        d0 = done_cnt;
        start = 1'b0;
        off = 0;
        check({name, "_busy_start"}, 32'(busy), 1);
        if (poke_start) begin
            @(negedge clk);
            start = 1'b1;
            a_flat = '1;
            b_flat = '1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int n = 0; n < 9; n++) begin
            if (n == stall_n) res_ready = 1'b0;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!res_valid && w < 20);
            if (!res_valid) begin
                check($sformatf("%s_timeout_e%0d", name, n), 0, 1);
                return;
            end
            if (n == abort_n) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs({name, "_abort"});
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
                check({name, "_abort_nodone"}, 32'(done_cnt), 32'(d0));
                check_idle_outputs({name, "_abort_after"});
                return;
            end
            check($sformatf("%s_data_e%0d", name, n), 32'(res_data), 32'(exp_c[n]));
            check($sformatf("%s_row_e%0d", name, n), 32'(res_row), 32'(n / 3));
            check($sformatf("%s_col_e%0d", name, n), 32'(res_col), 32'(n % 3));
            if (n == stall_n) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check($sformatf("%s_stall_valid_%0d", name, s), 32'(res_valid), 1);
                    check($sformatf("%s_stall_data_%0d", name, s), 32'(res_data), 32'(exp_c[n]));
                    check($sformatf("%s_stall_row_%0d", name, s), 32'(res_row), 32'(n / 3));
                    check($sformatf("%s_stall_col_%0d", name, s), 32'(res_col), 32'(n % 3));
                end
                res_ready = 1'b1;
                off = 5;
            end
            @(posedge clk);
            #1;
            check($sformatf("%s_accept_edge_e%0d", name, n), 32'(cyc), 32'(t0 + 4 * n + 4 + off));
        end
        check({name, "_done_high"}, 32'(done), 1);
        check({name, "_busy_done"}, 32'(busy), 0);
        if (poke_start) begin
            @(negedge clk);
            start = 1'b1;
            a_flat = '1;
            b_flat = '1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check({name, "_done_start_ignored"}, 32'(busy), 0);
        end else begin
            @(posedge clk);
            #1;
        end
        check({name, "_done_low"}, 32'(done), 0);
        check({name, "_done_count"}, 32'(done_cnt), 32'(d0 + 1));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        res_ready = 1'b1;
        a_flat = '0;
        b_flat = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_mm("seq",      pack(m_seq), pack(m_seq), c_seq, -1, 1'b0, -1);
        run_mm("ident",    pack(m_id),  pack(m_b2),  m_b2,  -1, 1'b0, -1);
        run_mm("max",      pack(m_max), pack(m_max), c_max, -1, 1'b0, -1);
        run_mm("stall",    pack(m_seq), pack(m_seq), c_seq,  1, 1'b0, -1);
        run_mm("ignore",   pack(m_seq), pack(m_seq), c_seq, -1, 1'b1, -1);
        run_mm("abort",    pack(m_seq), pack(m_seq), c_seq, -1, 1'b0,  4);
        run_mm("recover",  pack(m_seq), pack(m_seq), c_seq, -1, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mm3x3_mac_sched.md
Name: mm3x3_mac_sched

Overview:
- Sequencer that computes C = A x B for two 3x3 unsigned matrices by time-sharing one multiply-accumulate processing element.
- Captures both operand matrices on start, walks the output elements in row-major order, and accumulates three products per element.
- Streams each result out on a valid/ready port.
- Sits between the matrix load logic and the result sink in the 3x3 matrix-multiply datapath.

Parameters:
WIDTH, 4, bit width of each unsigned matrix element.
ACC_W, 2*WIDTH+2, result/accumulator width; holds 3*(2^WIDTH-1)^2 without overflow (derived, do not override).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new multiplication; sampled only in IDLE.
a_flat  input  9*WIDTH  matrix A, element [r][c] at bits (3r+c)*WIDTH +: WIDTH.
b_flat  input  9*WIDTH  matrix B, same packing as A.
busy  output  1  high in CALC and OUT.
res_valid  output  1  result element available.
res_ready  input  1  sink accepts the result.
res_data  output  ACC_W  value of C[res_row][res_col].
res_row  output  2  row index 0..2 of the current result.
res_col  output  2  column index 0..2 of the current result.
done  output  1  one-cycle pulse after the ninth result is accepted.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; i, j, k = 0; accumulator = 0; A and B registers = 0.
  - All outputs 0.
- States: IDLE, CALC, OUT, DONE.
- IDLE, start=1 at an edge:
  - Register a_flat and b_flat.
  - Clear i, j, k and the accumulator.
  - Go to CALC.
- IDLE, start=0: stay in IDLE; the operand registers hold their values.
- CALC, once per edge:
  - acc <= acc + A[i][k]*B[k][j]. Products are 2*WIDTH bits, zero-extended to ACC_W.
  - k increments. After the edge with k=2, go to OUT and reset k to 0.
- OUT:
  - res_valid=1, res_data=acc, res_row=i, res_col=j.
  - All four stay stable until res_valid&res_ready.
- Handshake in OUT:
  - If (i,j)=(2,2): go to DONE.
  - Otherwise advance j (wrap 2->0 and increment i), clear acc, go to CALC.
- DONE: done=1 for exactly one cycle, then IDLE.
- Output indices: res_row/res_col = 0 and res_data = 0 whenever res_valid=0.
- start is ignored outside IDLE, including in DONE. Operand changes after capture have no effect.
- Timing with res_ready tied high:
  - start sampled at edge T0.
  - Element n accepted at edge T0+4n+4.
  - done high in the cycle after edge T0+36; back in IDLE after T0+37.
- Throughput: 4 cycles per element minimum, plus any backpressure stall cycles.
- rst_n low mid-operation aborts immediately to reset state. No done pulse, no partial result.
- Arithmetic is unsigned; overflow is impossible at ACC_W.

Decomposition:
- Package mm_pkg holds:
  - WIDTH default and the ACC_W function.
  - State enum {IDLE, CALC, OUT, DONE}.
  - 2-bit index type.
  - Element-select helper for the flat packing.
- Sub-module mm_mac_pe (the PE):
  - Inputs: a, b (WIDTH), clr, en.
  - Output: acc (ACC_W).
  - Combinational multiply, registered accumulate.
  - Same clock and async active-low reset as the top.
- The top owns the FSM, counters, operand registers and the output port.

Test Plan:
- A=B=[[1,2,3],[4,5,6],[7,8,9]], res_ready=1 -> nine results in row-major order: 30,36,42,66,81,96,102,126,150. Indices match; done pulses one cycle after edge T0+36.
- A=identity, B=[[15,0,7],[1,2,3],[9,8,4]] -> results equal B element-wise.
- All elements 15 -> every result 675; no overflow at ACC_W=10.
- Hold res_ready low for 5 cycles while (0,1) is presented -> res_valid, res_data=36, row=0, col=1 stay stable; element (0,2) follows 4 cycles after acceptance.
- Pulse start during CALC with different operands -> ignored; results match the first operands; a single done pulse.
- Assert rst_n low during element (1,1) -> all outputs 0 asynchronously; no done. A following start gives a correct full run.
